// File: rtl/waveform_pkg.sv
// waveform_pkg: waveform mode enumeration and encodings shared by the generator
package waveform_pkg;
  typedef enum logic [1:0] {SAW = 2'd0, TRI = 2'd1, SQUARE = 2'd2, RSAW = 2'd3} wave_mode_e;
  localparam logic [1:0] MODE_SAW = 2'd0;
  localparam logic [1:0] MODE_TRI = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_RSAW = 2'd3;
endpackage

// File: rtl/pwm.sv
// pwm: free-running counter PWM, duty = level / 2**WIDTH, output registered
module pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] level,
  output logic             pwm_out
);
  logic [WIDTH-1:0] cnt;
  // counter runs only while enabled; output forced low when disabled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt <= enable ? cnt + WIDTH'(1) : '0;
      pwm_out <= enable && (cnt < level);
    end
endmodule

// File: rtl/step_timer.sv
// step_timer: runtime-loadable downcounter, one-clock tick every max(step_period,1) enabled clocks
module step_timer #(
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] step_period,
  output logic                    tick
);
  logic [PERIOD_WIDTH-1:0] cnt, reload;
  logic loaded;
  assign reload = (step_period == '0) ? '0 : step_period - PERIOD_WIDTH'(1);
  assign tick = enable && loaded && (cnt == '0);
  // count down; the period is only sampled when reloading so a change never truncates a count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      loaded <= 1'b0;
    end else begin
      loaded <= 1'b1;
      cnt <= (!enable || !loaded || tick) ? reload : cnt - PERIOD_WIDTH'(1);
    end
endmodule

// File: rtl/multi_waveform_gen.sv
// multi_waveform_gen: saw/triangle/square/reverse-saw level generator with R2R and PWM outputs; WAVEFORM_AMPLITUDE_EN adds amplitude scaling
module multi_waveform_gen
  import waveform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [PERIOD_WIDTH-1:0] step_period,
`ifdef WAVEFORM_AMPLITUDE_EN
  input  logic [WIDTH-1:0]        amplitude,
`endif
  output logic                    pwm_out,
  output logic [WIDTH-1:0]        r2r_out,
  output logic                    wrap,
  output logic [1:0]              active_mode
);
  localparam logic [WIDTH-1:0] MAX = '1;
  wave_mode_e cur;
  logic tick, dir, dir_n, at_wrap;
  logic [WIDTH-1:0] phase, phase_n, level, step_lvl, hold_lvl, init_lvl, out_lvl;

  step_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
    .clk(clk), .reset(reset), .enable(enable), .step_period(step_period), .tick(tick)
  );

  // next phase/direction and level for one tick; dir=1 means the triangle is descending
  always_comb begin
    phase_n = (cur == TRI && dir) ? phase - WIDTH'(1) : phase + WIDTH'(1);
    dir_n = (cur == TRI) ? (dir || (phase_n == MAX)) : 1'b0;
    at_wrap = (cur == TRI) ? (dir && phase == WIDTH'(1)) : (phase == MAX);
    step_lvl = (cur == RSAW) ? MAX - phase_n : (cur == SQUARE) ? {WIDTH{phase_n[WIDTH-1]}} : phase_n;
    init_lvl = (wave_mode_e'(mode) == RSAW) ? MAX : '0;
    hold_lvl = (cur == RSAW && phase == '0) ? MAX : level;
  end

  // waveform state; a pending mode change takes effect only on the wrap edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur <= SAW;
      phase <= '0;
      dir <= 1'b0;
      level <= '0;
      wrap <= 1'b0;
    end else if (!enable) begin
      cur <= wave_mode_e'(mode);
      phase <= '0;
      dir <= 1'b0;
      level <= '0;
      wrap <= 1'b0;
    end else if (tick && at_wrap) begin
      cur <= wave_mode_e'(mode);
      phase <= '0;
      dir <= 1'b0;
      level <= init_lvl;
      wrap <= 1'b1;
    end else if (tick) begin
      phase <= phase_n;
      dir <= dir_n;
      level <= step_lvl;
      wrap <= 1'b0;
    end else begin
      level <= hold_lvl;
      wrap <= 1'b0;
    end

`ifdef WAVEFORM_AMPLITUDE_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = (2*WIDTH)'(level) * (2*WIDTH)'(amplitude);
  // scaled level registered, adding one clock of latency
  always_ff @(posedge clk or posedge reset)
    if (reset) out_lvl <= '0;
    else out_lvl <= enable ? prod[2*WIDTH-1:WIDTH] : '0;
`else
  assign out_lvl = level;
`endif

  assign r2r_out = out_lvl;
  assign active_mode = cur;

  pwm #(.WIDTH(WIDTH)) u_pwm (
    .clk(clk), .reset(reset), .enable(enable), .level(out_lvl), .pwm_out(pwm_out)
  );
endmodule

// File: tb/tb_multi_waveform_gen.sv
// tb_multi_waveform_gen: directed vectors, corner sequences and random stimulus against a per-tick waveform model
module tb_multi_waveform_gen;
  localparam int W = 4;
  localparam int PW = 24;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [PW-1:0] step_period = 24'd1;
  logic pwm_out, wrap;
  logic [W-1:0] r2r_out;
  logic [1:0] active_mode;
  int tests = 0;
  int fails = 0;
  int m_rem, m_k, m_mode, m_lvl, m_wrap, m_pwm, m_pc, wraps, hi;

  typedef struct {int md; int sp; int n; int lvl; int wr;} vec_t;
  vec_t vt[15];

  multi_waveform_gen #(.WIDTH(W), .PERIOD_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .step_period(step_period),
    .pwm_out(pwm_out), .r2r_out(r2r_out), .wrap(wrap), .active_mode(active_mode)
  );

  always #5 clk = ~clk;

  // level at tick index k within one period of waveform md
  function automatic int wave(int md, int k);
    case (md)
      0: return k;
      1: return (k <= 15) ? k : 30 - k;
      2: return (k >= 8) ? 15 : 0;
      default: return 15 - k;
    endcase
  endfunction

  function automatic int plen(int md);
    return (md == 1) ? 30 : 16;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 1; m_k = 0; m_mode = 0; m_lvl = 0; m_wrap = 0; m_pwm = 0; m_pc = 0;
  endtask

  task automatic model_step();
    int p;
    p = (step_period == 0) ? 1 : int'(step_period);
    if (!enable) begin
      m_rem = p; m_k = 0; m_lvl = 0; m_wrap = 0; m_pwm = 0; m_pc = 0; m_mode = int'(mode);
    end else begin
      m_pwm = (m_pc < m_lvl) ? 1 : 0;
      m_pc = (m_pc + 1) % 16;
      m_wrap = 0;
      if (m_rem == 1) begin
        m_rem = p;
        m_k++;
        if (m_k == plen(m_mode)) begin
          m_k = 0;
          m_wrap = 1;
          m_mode = int'(mode);
        end
      end else m_rem--;
      m_lvl = wave(m_mode, m_k);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("r2r_out", int'(r2r_out), m_lvl);
    check("wrap", int'(wrap), m_wrap);
    check("active_mode", int'(active_mode), m_mode);
    check("pwm_out", int'(pwm_out), m_pwm);
    wraps += int'(wrap);
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_r2r", int'(r2r_out), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_mode", int'(active_mode), 0);
    check("rst_pwm", int'(pwm_out), 0);
    model_reset();
    enable = 1'b0;
    #1 reset = 1'b0;
  endtask

  initial begin
    vt[0] = '{0, 3, 3, 1, 0};
    vt[1] = '{0, 3, 47, 15, 0};
    vt[2] = '{0, 3, 48, 0, 1};
    vt[3] = '{0, 3, 96, 0, 2};
    vt[4] = '{1, 1, 15, 15, 0};
    vt[5] = '{1, 1, 16, 14, 0};
    vt[6] = '{1, 1, 30, 0, 1};
    vt[7] = '{1, 1, 31, 1, 1};
    vt[8] = '{3, 2, 1, 15, 0};
    vt[9] = '{3, 2, 2, 14, 0};
    vt[10] = '{3, 2, 32, 15, 1};
    vt[11] = '{2, 1, 8, 15, 0};
    vt[12] = '{2, 1, 7, 0, 0};
    vt[13] = '{2, 0, 16, 0, 1};
    vt[14] = '{0, 0, 5, 5, 0};
    #12;
    check("reset_r2r", int'(r2r_out), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_mode", int'(active_mode), 0);
    check("reset_pwm", int'(pwm_out), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cyc();
    for (int i = 0; i < 15; i++) begin
      enable = 1'b0;
      mode = 2'(vt[i].md);
      step_period = PW'(vt[i].sp);
      cyc();
      enable = 1'b1;
      wraps = 0;
      repeat (vt[i].n) cyc();
      check($sformatf("vec%0d_level", i), int'(r2r_out), vt[i].lvl);
      check($sformatf("vec%0d_wraps", i), wraps, vt[i].wr);
      check($sformatf("vec%0d_mode", i), int'(active_mode), vt[i].md);
    end
    enable = 1'b0; mode = 2'd0; step_period = 24'd1;
    cyc();
    enable = 1'b1;
    repeat (5) cyc();
    check("pend_start", int'(r2r_out), 5);
    mode = 2'd2;
    repeat (10) cyc();
    check("pend_hold_lvl", int'(r2r_out), 15);
    check("pend_hold_mode", int'(active_mode), 0);
    cyc();
    check("pend_apply_lvl", int'(r2r_out), 0);
    check("pend_apply_mode", int'(active_mode), 2);
    check("pend_apply_wrap", int'(wrap), 1);
    repeat (7) cyc();
    check("pend_sq_low", int'(r2r_out), 0);
    cyc();
    check("pend_sq_high", int'(r2r_out), 15);
    enable = 1'b0; mode = 2'd0; step_period = 24'd100;
    cyc();
    enable = 1'b1;
    repeat (400) cyc();
    check("pwm_level", int'(r2r_out), 4);
    hi = 0;
    repeat (16) begin
      cyc();
      hi += int'(pwm_out);
    end
    check("pwm_high_count", hi, 4);
    enable = 1'b0; mode = 2'd1; step_period = 24'd1;
    cyc();
    enable = 1'b1;
    repeat (9) cyc();
    check("tri_at9", int'(r2r_out), 9);
    async_reset();
    mode = 2'd0;
    cyc();
    check("restart_zero", int'(r2r_out), 0);
    enable = 1'b1;
    cyc();
    check("restart_one", int'(r2r_out), 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) enable = ~enable;
      if ($urandom_range(99) < 3) mode = 2'($urandom_range(3));
      if ($urandom_range(99) < 5) step_period = PW'($urandom_range(3));
      if ($urandom_range(999) < 3) async_reset();
      else if (!enable && $urandom_range(9) == 0) enable = 1'b1;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_waveform_gen.md
MULTI_WAVEFORM_GEN -- requirements
Module: multi_waveform_gen

Interface
REQ-001 Parameter WIDTH, default 8, level/PWM resolution in bits; MAX = 2**WIDTH-1.
REQ-002 Parameter PERIOD_WIDTH, default 24, width of the runtime step-period input.
REQ-003 clk  input  1  system clock (100 MHz); single clock domain.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  active-high run enable.
REQ-006 mode  input  2  requested waveform: 0 sawtooth, 1 triangle, 2 square, 3 reverse sawtooth.
REQ-007 step_period  input  PERIOD_WIDTH  clocks per level step.
REQ-008 pwm_out  output  1  registered PWM of current level.
REQ-009 r2r_out  output  WIDTH  current level, for the R2R ladder.
REQ-010 wrap  output  1  one-clock pulse marking the end of a waveform period.
REQ-011 active_mode  output  2  mode currently generated.

Function
REQ-012 Step timer: while enable=1, tick asserts for one clock every max(step_period,1) clocks; step_period=0 is treated as 1.
REQ-013 step_period is sampled at each tick reload; changes never truncate the count in progress.
REQ-014 The level register updates on the clock edge after tick (one-clock latency); r2r_out equals the level register.
REQ-015 Internal phase counter (WIDTH bits) plus direction bit advance once per tick.
REQ-016 Sawtooth: 0,1,...,MAX,0,...; wrap pulses on the MAX->0 step.
REQ-017 Reverse sawtooth: MAX,MAX-1,...,0,MAX,...; wrap pulses on the 0->MAX step.
REQ-018 Triangle: 0,1,...,MAX,MAX-1,...,1,0,1,...; period 2*MAX ticks; each endpoint is held for one tick only; wrap pulses on the 1->0 step.
REQ-019 Square: level = MAX when phase MSB=1, else 0; period 2**WIDTH ticks; wrap pulses when phase goes MAX->0.
REQ-020 A mode change while enabled is held pending and applied at the next wrap; the new mode starts at its initial phase on that same edge.
REQ-021 While enable=0: the timer is held at reload, phase=0, direction=up, level=0, pwm_out=0, wrap=0, and active_mode follows mode each clock.
REQ-022 On the first tick after enable rises, the level moves to the first step of active_mode (sawtooth/triangle 1, reverse MAX-1, square 0), with phase 0 counted as already emitted; reverse sawtooth shows MAX as its pre-first-tick level.
REQ-023 PWM: a free-running WIDTH-bit counter runs while enabled; pwm_out <= (pwm_cnt < level), so duty = level/2**WIDTH.
REQ-024 All arithmetic wraps modulo its declared width; no output shows X after reset.

Reset
REQ-025 Asynchronous assert: level=0, phase=0, direction=up, pwm_cnt=0, pwm_out=0, wrap=0, active_mode=0 (sawtooth), pending mode cleared, timer at reload.
REQ-026 Reset during operation aborts the period immediately; no wrap pulse is produced for the aborted period.

Configuration
REQ-027 Macro WAVEFORM_AMPLITUDE_EN: when defined, adds input amplitude [WIDTH-1:0], and the output level = (raw_level*amplitude)>>WIDTH, computed in a 2*WIDTH-bit product and registered (one extra clock latency on r2r_out and pwm_out).
REQ-028 Without WAVEFORM_AMPLITUDE_EN, the amplitude port does not exist, the raw level drives outputs directly, and REQ-014 latency holds.

Structure
REQ-029 Package waveform_pkg holds typedef enum wave_mode_e (SAW, TRI, SQUARE, RSAW) and mode encoding constants.
REQ-030 Sub-module step_timer (runtime-loadable downcounter producing tick); reuse the existing pwm block for PWM generation.

Verification
REQ-031 WIDTH=4, sawtooth, step_period=3: level increments every 3 clocks, 15->0 after 48 clocks, and wrap pulses once per 48 clocks.
REQ-032 WIDTH=4, triangle, step_period=1: sequence 0..15..1,0 with no repeated endpoints; wrap pulses every 30 clocks.
REQ-033 Sawtooth at level 5, mode set to square: active_mode stays 0 until the 15->0 wrap, then becomes 2 and the level is 0 for 8 ticks, then 15 for 8 ticks.
REQ-034 step_period=0: level steps every clock, identical to step_period=1.
REQ-035 WIDTH=4, level held at 4: pwm_out is high for exactly 4 of every 16 clocks.
REQ-036 Reset asserted asynchronously mid-triangle at level 9: outputs go to 0 before the next clk edge, with no wrap pulse; after release, the sawtooth restarts from 0.
